// File: rtl/l1d_data_array_if.sv
// Core/L2-facing data bus of the L1D data array: set/way select, strobes,
// store and refill data in, core word and victim line out.
`timescale 1ns/1ps
interface l1d_data_array_if #(
  parameter int INUM   = 5,
  parameter int L1CBUS = 32,
  parameter int L21BUS = 512
);
  logic [INUM-1:0]   index_C_L1;
  logic [5:0]        offset;
  logic [L1CBUS-1:0] write_data_C_L1;
  logic [L21BUS-1:0] read_data_L2_L1;
  logic              update;
  logic              refill;
  logic              way;
  logic [L1CBUS-1:0] read_data_L1_C;
  logic [L21BUS-1:0] write_data_L1_L2;

  modport master (
    output index_C_L1, offset, write_data_C_L1, read_data_L2_L1,
    output update, refill, way,
    input  read_data_L1_C, write_data_L1_L2
  );

  modport slave (
    input  index_C_L1, offset, write_data_C_L1, read_data_L2_L1,
    input  update, refill, way,
    output read_data_L1_C, write_data_L1_L2
  );
endinterface

// File: rtl/l1d_data_array.sv
// L1D line storage: 2 ways x 2^INUM sets of 512-bit lines, read-first word/line
// read port with one-cycle latency, word store, line refill and merged refill+store.
`timescale 1ns/1ps
module l1d_data_array #(
  parameter int TNUM   = 21,
  parameter int INUM   = 26 - TNUM,
  parameter int L1CBUS = 32,
  parameter int L21BUS = 512
) (
  input  logic               clk,
  input  logic               nrst,
  l1d_data_array_if.slave    bus
);

  localparam int WORDS = L21BUS / L1CBUS;
  localparam int WSEL  = $clog2(WORDS);
  localparam int NSETS = 1 << INUM;
  localparam int DEPTH = 2 * NSETS;

  if (TNUM + INUM + 6 != 32) begin : g_bad_addr_split
    $error("l1d_data_array: TNUM + INUM + 6 must equal 32");
  end

  logic [L21BUS-1:0] mem [DEPTH];

  // Way is the MSB of the flat entry address so each way is a contiguous bank.
  logic [INUM:0]     addr;
  logic [WSEL-1:0]   word_sel;
  logic [L21BUS-1:0] cur_line;
  logic [L21BUS-1:0] new_line;
  logic [L1CBUS-1:0] cur_words [WORDS];
  logic              write_en;

  assign addr     = {bus.way, bus.index_C_L1};
  assign word_sel = bus.offset[2 +: WSEL];
  assign cur_line = mem[addr];
  assign write_en = bus.update | bus.refill;

  // Per word: the store word wins, otherwise refill data, otherwise keep.
  // A merged refill+store therefore yields the L2 line with one word replaced.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign cur_words[gi] = cur_line[gi*L1CBUS +: L1CBUS];
    assign new_line[gi*L1CBUS +: L1CBUS] =
        (bus.update && (word_sel == WSEL'(gi))) ? bus.write_data_C_L1 :
        bus.refill                              ? bus.read_data_L2_L1[gi*L1CBUS +: L1CBUS] :
                                                  cur_words[gi];
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      bus.read_data_L1_C   <= '0;
      bus.write_data_L1_L2 <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // Outputs sample pre-write contents, so a refill edge exposes the victim line.
      bus.read_data_L1_C   <= cur_words[word_sel];
      bus.write_data_L1_L2 <= cur_line;
      if (write_en) begin
        mem[addr] <= new_line;
      end
    end
  end

endmodule

// File: tb/tb_l1d_data_array.sv
// Directed bench for l1d_data_array: reset, refill, way isolation, store,
// merged refill+store, victim readout and back-to-back stores.
`timescale 1ns/1ps
module tb_l1d_data_array;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  l1d_data_array_if bus ();

  l1d_data_array dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] mk_line(input logic [31:0] base);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
    return l;
  endfunction

  // Inputs change on the falling edge; outputs are checked on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cmd(input logic [4:0] idx, input logic w, input logic [5:0] off,
                         input logic upd, input logic ref_, input logic [31:0] wd,
                         input logic [511:0] ld);
    bus.index_C_L1      = idx;
    bus.way             = w;
    bus.offset          = off;
    bus.update          = upd;
    bus.refill          = ref_;
    bus.write_data_C_L1 = wd;
    bus.read_data_L2_L1 = ld;
    $display("txn idx=%0d way=%0d off=%h update=%0b refill=%0b wd=%h", idx, w, off, upd, ref_, wd);
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    set_cmd(5'd0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0, '0);
    repeat (3) tick();
    checks++;
    if (bus.read_data_L1_C !== 32'h0) begin
      errors++; $display("FAIL reset_word: got %h expected %h", bus.read_data_L1_C, 32'h0);
    end
    checks++;
    if (bus.write_data_L1_L2 !== 512'h0) begin
      errors++; $display("FAIL reset_line: got %h expected 0", bus.write_data_L1_L2);
    end
    nrst = 1'b0;
    tick();
  endtask

  task automatic test_refill();
    logic [511:0] l0;
    l0 = mk_line(32'h1000);
    set_cmd(5'd3, 1'b0, 6'h24, 1'b0, 1'b1, 32'h0, l0);
    tick();
    checks++;
    if (bus.read_data_L1_C !== 32'h0) begin
      errors++; $display("FAIL refill_readfirst: got %h expected %h", bus.read_data_L1_C, 32'h0);
    end
    bus.refill = 1'b0;
    bus.read_data_L2_L1 = 'x;
    tick();
    checks++;
    if (bus.read_data_L1_C !== 32'h1009) begin
      errors++; $display("FAIL refill_word9: got %h expected %h", bus.read_data_L1_C, 32'h1009);
    end
    checks++;
    if (bus.write_data_L1_L2 !== l0) begin
      errors++; $display("FAIL refill_line: got %h expected %h", bus.write_data_L1_L2, l0);
    end
  endtask

  task automatic test_way_isolation();
    set_cmd(5'd3, 1'b1, 6'h3C, 1'b0, 1'b1, 32'h0, mk_line(32'h2000));
    tick();
    bus.refill = 1'b0;
    tick();
    checks++;
    if (bus.read_data_L1_C !== 32'h200F) begin
      errors++; $display("FAIL way1_word15: got %h expected %h", bus.read_data_L1_C, 32'h200F);
    end
    set_cmd(5'd3, 1'b0, 6'h24, 1'b0, 1'b0, 32'h0, 'x);
    tick();
    checks++;
    if (bus.read_data_L1_C !== 32'h1009) begin
      errors++; $display("FAIL way0_intact: got %h expected %h", bus.read_data_L1_C, 32'h1009);
    end
    checks++;
    if (bus.write_data_L1_L2 !== mk_line(32'h1000)) begin
      errors++; $display("FAIL way0_line_intact: got %h expected %h", bus.write_data_L1_L2, mk_line(32'h1000));
    end
  endtask

  task automatic test_store();
    logic [511:0] exp_line;
    exp_line = mk_line(32'h1000);
    exp_line[32*2 +: 32] = 32'hDEADBEEF;
    set_cmd(5'd3, 1'b0, 6'h08, 1'b1, 1'b0, 32'hDEADBEEF, 'x);
    tick();
    bus.update = 1'b0;
    bus.write_data_C_L1 = 'x;
    tick();
    checks++;
    if (bus.read_data_L1_C !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_word2: got %h expected %h", bus.read_data_L1_C, 32'hDEADBEEF);
    end
    checks++;
    if (bus.write_data_L1_L2 !== exp_line) begin
      errors++; $display("FAIL store_line: got %h expected %h", bus.write_data_L1_L2, exp_line);
    end
    bus.offset = 6'h0D;
    tick();
    checks++;
    if (bus.read_data_L1_C !== 32'h1003) begin
      errors++; $display("FAIL store_word3: got %h expected %h", bus.read_data_L1_C, 32'h1003);
    end
    bus.way = 1'b1;
    tick();
    checks++;
    if (bus.write_data_L1_L2 !== mk_line(32'h2000)) begin
      errors++; $display("FAIL store_other_way: got %h expected %h", bus.write_data_L1_L2, mk_line(32'h2000));
    end
  endtask

  task automatic test_merge();
    set_cmd(5'd7, 1'b1, 6'h10, 1'b1, 1'b1, 32'hCAFEF00D, mk_line(32'h3000));
    repeat (2) tick();
    bus.update = 1'b0;
    bus.refill = 1'b0;
    tick();
    checks++;
    if (bus.read_data_L1_C !== 32'hCAFEF00D) begin
      errors++; $display("FAIL merge_word4: got %h expected %h", bus.read_data_L1_C, 32'hCAFEF00D);
    end
    bus.offset = 6'h14;
    tick();
    checks++;
    if (bus.read_data_L1_C !== 32'h3005) begin
      errors++; $display("FAIL merge_word5: got %h expected %h", bus.read_data_L1_C, 32'h3005);
    end
    bus.offset = 6'h0C;
    tick();
    checks++;
    if (bus.read_data_L1_C !== 32'h3003) begin
      errors++; $display("FAIL merge_word3: got %h expected %h", bus.read_data_L1_C, 32'h3003);
    end
  endtask

  task automatic test_victim();
    logic [511:0] old_line;
    logic [511:0] new_line;
    old_line = mk_line(32'h1000);
    old_line[32*2 +: 32] = 32'hDEADBEEF;
    new_line = mk_line(32'h4000);
    set_cmd(5'd3, 1'b0, 6'h08, 1'b0, 1'b1, 32'h0, new_line);
    tick();
    checks++;
    if (bus.write_data_L1_L2 !== old_line) begin
      errors++; $display("FAIL victim_line: got %h expected %h", bus.write_data_L1_L2, old_line);
    end
    checks++;
    if (bus.read_data_L1_C !== 32'hDEADBEEF) begin
      errors++; $display("FAIL victim_word: got %h expected %h", bus.read_data_L1_C, 32'hDEADBEEF);
    end
    bus.refill = 1'b0;
    tick();
    checks++;
    if (bus.write_data_L1_L2 !== new_line) begin
      errors++; $display("FAIL victim_newline: got %h expected %h", bus.write_data_L1_L2, new_line);
    end
    checks++;
    if (bus.read_data_L1_C !== 32'h4002) begin
      errors++; $display("FAIL victim_newword: got %h expected %h", bus.read_data_L1_C, 32'h4002);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    for (int i = 0; i < 4; i++) begin
      set_cmd(5'd10, 1'b0, 6'(4*i + 1), 1'b1, 1'b0, 32'hA0 + 32'(i), 'x);
      tick();
    end
    bus.update = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.offset = 6'(4*i);
      tick();
      exp_w = (i < 4) ? 32'hA0 + 32'(i) : 32'h0;
      checks++;
      if (bus.read_data_L1_C !== exp_w) begin
        errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, bus.read_data_L1_C, exp_w);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_cmd(5'd3, 1'b0, 6'h24, 1'b0, 1'b0, 32'h0, 'x);
    tick();
    nrst = 1'b1;
    #1;
    checks++;
    if (bus.read_data_L1_C !== 32'h0) begin
      errors++; $display("FAIL midreset_word: got %h expected %h", bus.read_data_L1_C, 32'h0);
    end
    checks++;
    if (bus.write_data_L1_L2 !== 512'h0) begin
      errors++; $display("FAIL midreset_line: got %h expected 0", bus.write_data_L1_L2);
    end
    repeat (5) tick();
    nrst = 1'b0;
    tick();
    checks++;
    if (bus.read_data_L1_C !== 32'h0) begin
      errors++; $display("FAIL postreset_word: got %h expected %h", bus.read_data_L1_C, 32'h0);
    end
    set_cmd(5'd7, 1'b1, 6'h10, 1'b0, 1'b0, 32'h0, 'x);
    tick();
    checks++;
    if (bus.write_data_L1_L2 !== 512'h0) begin
      errors++; $display("FAIL postreset_line: got %h expected 0", bus.write_data_L1_L2);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nrst   = 1'b1;
    set_cmd(5'd0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0, '0);
    @(negedge clk);
    test_reset();
    test_refill();
    test_way_isolation();
    test_store();
    test_merge();
    test_victim();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1d_data_array.md
Name: l1d_data_array

Overview:
- Data storage for the L1 data cache: 2-way set-associative, 64-byte lines, 2^INUM sets.
- Serves 32-bit word reads and stores to the core.
- Accepts full 512-bit line refills from L2.
- Presents the full selected line toward L2 for write-back of an evicted line.
- Tag, valid, dirty and LRU state live in a separate tag array and controller; this block receives the resolved set index, way and command strobes.

Parameters:
- TNUM, 21, number of tag bits (address[31:32-TNUM]); used only to derive INUM.
- INUM, 26-TNUM (=5), number of index bits; number of sets = 2^INUM.
- L1CBUS, 32, core-side data word width.
- L21BUS, 512, L2-to-L1 line width (64 bytes = 16 words).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- nrst  in  1  reset; asynchronous and active-high (asserted = 1), despite the name.
- index_C_L1  in  INUM  set index (address[6+:INUM]).
- offset  in  6  byte offset within the line (address[5:0]); word select = offset[5:2]; offset[1:0] ignored.
- write_data_C_L1  in  L1CBUS  store data from the core.
- read_data_L2_L1  in  L21BUS  refill line from L2.
- update  in  1  store strobe: write one word into the selected line.
- refill  in  1  refill strobe: write the whole selected line from L2.
- way  in  1  selected way (0/1), already resolved by the controller.
- read_data_L1_C  out  L1CBUS  word read for the core.
- write_data_L1_L2  out  L21BUS  full selected line toward L2 (write-back of evicted line).

Behaviour:
- Storage: mem[way][set] of L21BUS bits. Word w of a line occupies bits [32*w +: 32], with w = offset[5:2] and word 0 at the LSBs.
- Reset (nrst=1, asynchronous):
  - read_data_L1_C = 0 and write_data_L1_L2 = 0 immediately.
  - All mem entries cleared to 0.
  - Held while nrst=1; the first write is possible on the first rising edge after deassertion.
- Read path:
  - Every rising edge (not in reset), read_data_L1_C <= mem[way][index][32*offset[5:2] +: 32].
  - On the same edge, write_data_L1_L2 <= mem[way][index].
  - Latency 1 cycle from index/offset/way to output.
- Read-during-write: both outputs capture contents from before that edge's write (read-first). write_data_L1_L2 therefore carries the old (victim) line on the refill edge. The new data is visible on the next edge if the inputs are held.
- Write on the rising edge, per strobe combination:
  - refill=1, update=0: mem[way][index] <= read_data_L2_L1.
  - refill=0, update=1: only word offset[5:2] of mem[way][index] <= write_data_C_L1; the other 15 words are unchanged.
  - refill=1, update=1 (write-allocate merge): mem[way][index] <= read_data_L2_L1 with word offset[5:2] replaced by write_data_C_L1.
  - refill=0, update=0: no write.
- Writes touch only the addressed way and set; the other way of the same set is never modified.
- Strobes are level-sensitive: held high for N cycles, the write repeats each edge (idempotent with stable inputs).
- No handshake or busy state; a new index/way/command is accepted every cycle.
- Inputs are sampled only at the rising edge; X on an unused data input is ignored when its strobe is low.

Test Plan:
- Reset then read: pulse nrst=1 for 5 cycles mid-operation -> both outputs 0 immediately; any set/way/offset reads 0 after release.
- Refill way0: index=3, way=0, refill=1, read_data_L2_L1 word k = 0x1000+k, one edge; then refill=0 and hold -> next edge read_data_L1_C = 0x1000+offset[5:2] (offset=0x24 -> 0x1009); write_data_L1_L2 = the full line.
- Way isolation: refill index=3 way=1 with words 0x2000+k -> way1 offset=0x3C reads 0x200F; way0 offset=0x24 still reads 0x1009.
- Store hit: index=3, way=0, offset=0x08, update=1, write_data_C_L1=0xDEADBEEF, one edge -> that word reads 0xDEADBEEF; words 0..1 and 3..15 unchanged (word 3 = 0x1003).
- Merged refill+store: index=7, way=1, offset=0x10, refill=update=1, line words 0x3000+k, store 0xCAFEF00D -> word 4 = 0xCAFEF00D, word 5 = 0x3005.
- Victim readout: on the refill edge to index=3 way=0 with new data, write_data_L1_L2 shows the old line (0x1000.. with word 2 = 0xDEADBEEF); the new line appears one edge later.
